bram_port_arbiter: RTL and testbench

- Shares the single-port configuration/tap BRAM between two requesters: port 0 = AXI4-Lite slave side, port 1 = compute-engine side.
- Round-robin arbitration with bounded burst hold, address range/alignment checking, and a read-latency-matched response pipeline that routes BRAM read data back to the issuing port.
- Sits between the requesters and the BRAM macro; it is the only driver of the BRAM pins.

---
 rtl/bram_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_bram_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port BRAM, with burst-hold fairness,
// address checking and a latency-matched response pipeline. Optional counters: BRAM_ARB_STAT_EN.
module bram_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BRAM_DEPTH = 11,
  parameter int RD_LATENCY = 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    in_p0_valid,
  output logic                    out_p0_ready,
  input  logic [ADDR_WIDTH-1:0]   in_p0_addr,
  input  logic [DATA_WIDTH/8-1:0] in_p0_we,
  input  logic [DATA_WIDTH-1:0]   in_p0_wdata,
  output logic                    out_p0_rsp_valid,
  output logic [DATA_WIDTH-1:0]   out_p0_rsp_rdata,
  output logic                    out_p0_rsp_err,
  input  logic                    in_p1_valid,
  output logic                    out_p1_ready,
  input  logic [ADDR_WIDTH-1:0]   in_p1_addr,
  input  logic [DATA_WIDTH/8-1:0] in_p1_we,
  input  logic [DATA_WIDTH-1:0]   in_p1_wdata,
  output logic                    out_p1_rsp_valid,
  output logic [DATA_WIDTH-1:0]   out_p1_rsp_rdata,
  output logic                    out_p1_rsp_err,
  output logic                    out_EN,
  output logic [DATA_WIDTH/8-1:0] out_WE,
  output logic [ADDR_WIDTH-1:0]   out_A,
  output logic [DATA_WIDTH-1:0]   out_Di,
  input  logic [DATA_WIDTH-1:0]   in_Do
`ifdef BRAM_ARB_STAT_EN
  ,
  input  logic                    in_stat_clr,
  output logic [31:0]             out_p0_cnt,
  output logic [31:0]             out_p1_cnt,
  output logic [31:0]             out_stall_cnt
`endif
);

  localparam int          WE_W    = DATA_WIDTH / 8;
  localparam int          BW      = $clog2(MAX_BURST + 1);
  localparam logic [31:0] DEPTH_U = BRAM_DEPTH;

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
    logic  is_read;
    logic  err;
  } stage_t;

  port_e           owner_q, owner_d, sel;
  logic [BW-1:0]   burst_q, burst_d;
  stage_t          pipe_q [RD_LATENCY];
  stage_t          stage_in, rsp;
  logic            own_v, oth_v, serve, grant, err;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WE_W-1:0]       sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      owner_q <= PORT0;
      burst_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      owner_q   <= owner_d;
      burst_q   <= burst_d;
      pipe_q[0] <= stage_in;
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // Owner keeps the port while under its burst allowance, or indefinitely if the other side is idle.
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    serve   = 1'b0;
    sel     = owner_q;
    own_v   = (owner_q == PORT0) ? in_p0_valid : in_p1_valid;
    oth_v   = (owner_q == PORT0) ? in_p1_valid : in_p0_valid;
    if (own_v && ((burst_q < BW'(MAX_BURST)) || !oth_v)) begin
      serve = 1'b1;
      if (burst_q < BW'(MAX_BURST)) burst_d = burst_q + BW'(1);
    end else if (oth_v) begin
      serve   = 1'b1;
      sel     = (owner_q == PORT0) ? PORT1 : PORT0;
      owner_d = sel;
      burst_d = BW'(1);
    end else begin
      burst_d = '0;
    end
  end

  always_comb begin
    grant     = serve && !areset;
    sel_addr  = (sel == PORT0) ? in_p0_addr  : in_p1_addr;
    sel_we    = (sel == PORT0) ? in_p0_we    : in_p1_we;
    sel_wdata = (sel == PORT0) ? in_p0_wdata : in_p1_wdata;
    err       = (sel_addr[1:0] != 2'b00) || (32'(sel_addr[ADDR_WIDTH-1:2]) >= DEPTH_U);

    out_p0_ready = grant && (sel == PORT0);
    out_p1_ready = grant && (sel == PORT1);

    out_EN = 1'b0;
    out_WE = '0;
    out_A  = '0;
    out_Di = '0;
    if (grant && !err) begin
      out_EN = 1'b1;
      out_WE = sel_we;
      out_A  = sel_addr;
      out_Di = sel_wdata;
    end

    stage_in.valid   = grant;
    stage_in.port    = sel;
    stage_in.is_read = (sel_we == '0);
    stage_in.err     = err;
  end

  always_comb begin
    rsp              = pipe_q[RD_LATENCY-1];
    out_p0_rsp_valid = rsp.valid && (rsp.port == PORT0);
    out_p1_rsp_valid = rsp.valid && (rsp.port == PORT1);
    out_p0_rsp_err   = out_p0_rsp_valid && rsp.err;
    out_p1_rsp_err   = out_p1_rsp_valid && rsp.err;
    out_p0_rsp_rdata = (out_p0_rsp_valid && rsp.is_read && !rsp.err) ? in_Do : '0;
    out_p1_rsp_rdata = (out_p1_rsp_valid && rsp.is_read && !rsp.err) ? in_Do : '0;
  end

`ifdef BRAM_ARB_STAT_EN
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_p0_cnt    <= '0;
      out_p1_cnt    <= '0;
      out_stall_cnt <= '0;
    end else if (in_stat_clr) begin
      out_p0_cnt    <= '0;
      out_p1_cnt    <= '0;
      out_stall_cnt <= '0;
    end else begin
      if (out_p0_ready) out_p0_cnt <= out_p0_cnt + 32'd1;
      if (out_p1_ready) out_p1_cnt <= out_p1_cnt + 32'd1;
      if ((in_p0_valid && !out_p0_ready) || (in_p1_valid && !out_p1_ready))
        out_stall_cnt <= out_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a 1-cycle-latency BRAM model.
module tb_bram_port_arbiter;

  logic        aclk = 1'b0;
  logic        areset;
  logic        p0_valid, p1_valid, p0_ready, p1_ready;
  logic [11:0] p0_addr, p1_addr;
  logic [3:0]  p0_we, p1_we;
  logic [31:0] p0_wdata, p1_wdata;
  logic        p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic        out_EN;
  logic [3:0]  out_WE;
  logic [11:0] out_A;
  logic [31:0] out_Di;
  logic [31:0] in_Do = '0;
  logic [31:0] mem [0:15];
  int          n_cmp = 0;
  int          n_bad = 0;
`ifdef BRAM_ARB_STAT_EN
  logic        stat_clr = 1'b0;
  logic [31:0] p0_cnt, p1_cnt, stall_cnt;
`endif

  always #5 aclk = ~aclk;

  bram_port_arbiter #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .BRAM_DEPTH(11), .RD_LATENCY(1), .MAX_BURST(4)
  ) dut (
    .aclk(aclk), .areset(areset),
    .in_p0_valid(p0_valid), .out_p0_ready(p0_ready), .in_p0_addr(p0_addr),
    .in_p0_we(p0_we), .in_p0_wdata(p0_wdata),
    .out_p0_rsp_valid(p0_rsp_valid), .out_p0_rsp_rdata(p0_rsp_rdata), .out_p0_rsp_err(p0_rsp_err),
    .in_p1_valid(p1_valid), .out_p1_ready(p1_ready), .in_p1_addr(p1_addr),
    .in_p1_we(p1_we), .in_p1_wdata(p1_wdata),
    .out_p1_rsp_valid(p1_rsp_valid), .out_p1_rsp_rdata(p1_rsp_rdata), .out_p1_rsp_err(p1_rsp_err),
    .out_EN(out_EN), .out_WE(out_WE), .out_A(out_A), .out_Di(out_Di), .in_Do(in_Do)
`ifdef BRAM_ARB_STAT_EN
    , .in_stat_clr(stat_clr), .out_p0_cnt(p0_cnt), .out_p1_cnt(p1_cnt), .out_stall_cnt(stall_cnt)
`endif
  );

  // Read-first single-port BRAM, one cycle read latency.
  always @(posedge aclk) begin
    if (out_EN) begin
      for (int b = 0; b < 4; b++)
        if (out_WE[b]) mem[out_A[5:2]][8*b +: 8] <= out_Di[8*b +: 8];
      in_Do <= mem[out_A[5:2]];
    end
  end

  task automatic idle();
    p0_valid = 0; p0_addr = '0; p0_we = '0; p0_wdata = '0;
    p1_valid = 0; p1_addr = '0; p1_we = '0; p1_wdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    idle();
    areset = 1;
    next_cycle();
    areset = 0;
  endtask

  task automatic test_reset();
    areset = 1;
    p0_valid = 1; p0_addr = 12'h008; p1_valid = 1; p1_addr = 12'h00C;
    @(negedge aclk);
    n_cmp++;
    if (p0_ready !== 1'b0 || p1_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_ready: p0=%b p1=%b want 0 0", p0_ready, p1_ready);
    end
    n_cmp++;
    if (out_EN !== 1'b0 || out_WE !== 4'h0 || out_A !== 12'h0 || out_Di !== 32'h0) begin
      n_bad++; $display("FAIL reset_bram: EN=%b WE=%h A=%h Di=%h want all 0", out_EN, out_WE, out_A, out_Di);
    end
    next_cycle();
    idle();
    areset = 0;
    @(negedge aclk);
    n_cmp++;
    if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0 || p0_rsp_rdata !== 32'h0 || out_EN !== 1'b0) begin
      n_bad++; $display("FAIL reset_after: rsp0=%b rsp1=%b rdata0=%h EN=%b want 0", p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, out_EN);
    end
    next_cycle();
  endtask

  task automatic test_read();
    p0_valid = 1; p0_addr = 12'h008; p0_we = 4'h0;
    @(negedge aclk);
    n_cmp++;
    if (p0_ready !== 1'b1 || p1_ready !== 1'b0 || out_EN !== 1'b1 || out_A !== 12'h008 || out_WE !== 4'h0) begin
      n_bad++; $display("FAIL read_issue: rdy0=%b rdy1=%b EN=%b A=%h WE=%h want 1 0 1 008 0", p0_ready, p1_ready, out_EN, out_A, out_WE);
    end
    next_cycle();
    idle();
    @(negedge aclk);
    n_cmp++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'hDEADBEEF || p0_rsp_err !== 1'b0 || p1_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL read_rsp: v0=%b rdata=%h err=%b v1=%b want 1 deadbeef 0 0", p0_rsp_valid, p0_rsp_rdata, p0_rsp_err, p1_rsp_valid);
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic exp0, prev0;
    do_reset();
    p0_valid = 1; p0_addr = 12'h000; p1_valid = 1; p1_addr = 12'h00C;
    prev0 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp0 = (i < 4) || (i >= 8);
      @(negedge aclk);
      n_cmp++;
      if (p0_ready !== exp0 || p1_ready !== ~exp0 || out_EN !== 1'b1) begin
        n_bad++; $display("FAIL contention_grant[%0d]: rdy0=%b rdy1=%b EN=%b want %b %b 1", i, p0_ready, p1_ready, out_EN, exp0, ~exp0);
      end
      if (i > 0) begin
        n_cmp++;
        if (p0_rsp_valid !== prev0 || p1_rsp_valid !== ~prev0 ||
            (prev0 ? p0_rsp_rdata : p1_rsp_rdata) !== (prev0 ? 32'h11110000 : 32'h33333333)) begin
          n_bad++; $display("FAIL contention_rsp[%0d]: v0=%b v1=%b d0=%h d1=%h want v0=%b", i, p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata, p1_rsp_rdata, prev0);
        end
      end
      prev0 = exp0;
      next_cycle();
    end
    idle();
    @(negedge aclk);
    n_cmp++;
    if (p0_rsp_valid !== 1'b1 || p1_rsp_valid !== 1'b0 || p0_rsp_rdata !== 32'h11110000) begin
      n_bad++; $display("FAIL contention_last: v0=%b v1=%b d0=%h want 1 0 11110000", p0_rsp_valid, p1_rsp_valid, p0_rsp_rdata);
    end
`ifdef BRAM_ARB_STAT_EN
    n_cmp++;
    if (p0_cnt !== 32'd8 || p1_cnt !== 32'd4 || stall_cnt !== 32'd12) begin
      n_bad++; $display("FAIL stat_counts: p0=%0d p1=%0d stall=%0d want 8 4 12", p0_cnt, p1_cnt, stall_cnt);
    end
    next_cycle();
    stat_clr = 1;
    next_cycle();
    stat_clr = 0;
    @(negedge aclk);
    n_cmp++;
    if (p0_cnt !== 32'd0 || p1_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
      n_bad++; $display("FAIL stat_clear: p0=%0d p1=%0d stall=%0d want 0 0 0", p0_cnt, p1_cnt, stall_cnt);
    end
`endif
    next_cycle();
  endtask

  task automatic test_write_read();
    p1_valid = 1; p1_addr = 12'h004; p1_we = 4'b0011; p1_wdata = 32'h12345678;
    @(negedge aclk);
    n_cmp++;
    if (p1_ready !== 1'b1 || p0_ready !== 1'b0 || out_EN !== 1'b1 || out_WE !== 4'b0011 ||
        out_A !== 12'h004 || out_Di !== 32'h12345678) begin
      n_bad++; $display("FAIL write_issue: rdy1=%b EN=%b WE=%b A=%h Di=%h want 1 1 0011 004 12345678", p1_ready, out_EN, out_WE, out_A, out_Di);
    end
    next_cycle();
    p1_we = 4'h0; p1_wdata = '0;
    @(negedge aclk);
    n_cmp++;
    if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== 32'h0 || p1_rsp_err !== 1'b0 || p0_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL write_rsp: v1=%b rdata=%h err=%b v0=%b want 1 0 0 0", p1_rsp_valid, p1_rsp_rdata, p1_rsp_err, p0_rsp_valid);
    end
    n_cmp++;
    if (p1_ready !== 1'b1 || out_EN !== 1'b1 || out_WE !== 4'h0 || out_A !== 12'h004) begin
      n_bad++; $display("FAIL reread_issue: rdy1=%b EN=%b WE=%h A=%h want 1 1 0 004", p1_ready, out_EN, out_WE, out_A);
    end
    next_cycle();
    idle();
    @(negedge aclk);
    n_cmp++;
    if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== 32'hAABB5678 || p0_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL reread_rsp: v1=%b rdata=%h v0=%b want 1 aabb5678 0", p1_rsp_valid, p1_rsp_rdata, p0_rsp_valid);
    end
    next_cycle();
  endtask

  task automatic test_errors();
    p0_valid = 1; p0_addr = 12'h02C; p0_we = 4'hF; p0_wdata = 32'hBAD0BAD0;
    @(negedge aclk);
    n_cmp++;
    if (p0_ready !== 1'b1 || out_EN !== 1'b0 || out_WE !== 4'h0) begin
      n_bad++; $display("FAIL err_range_issue: rdy0=%b EN=%b WE=%h want 1 0 0", p0_ready, out_EN, out_WE);
    end
    next_cycle();
    p0_addr = 12'h005; p0_we = 4'h0; p0_wdata = '0;
    @(negedge aclk);
    n_cmp++;
    if (p0_ready !== 1'b1 || out_EN !== 1'b0) begin
      n_bad++; $display("FAIL err_align_issue: rdy0=%b EN=%b want 1 0", p0_ready, out_EN);
    end
    n_cmp++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_err !== 1'b1 || p0_rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL err_range_rsp: v0=%b err=%b rdata=%h want 1 1 0", p0_rsp_valid, p0_rsp_err, p0_rsp_rdata);
    end
    next_cycle();
    p0_addr = 12'h000;
    @(negedge aclk);
    n_cmp++;
    if (p0_ready !== 1'b1 || out_EN !== 1'b1 || out_A !== 12'h000) begin
      n_bad++; $display("FAIL err_recover_issue: rdy0=%b EN=%b A=%h want 1 1 000", p0_ready, out_EN, out_A);
    end
    n_cmp++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_err !== 1'b1 || p0_rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL err_align_rsp: v0=%b err=%b rdata=%h want 1 1 0", p0_rsp_valid, p0_rsp_err, p0_rsp_rdata);
    end
    next_cycle();
    idle();
    @(negedge aclk);
    n_cmp++;
    if (p0_rsp_valid !== 1'b1 || p0_rsp_err !== 1'b0 || p0_rsp_rdata !== 32'h11110000 || mem[11] !== 32'h0B0B0B0B) begin
      n_bad++; $display("FAIL err_recover_rsp: v0=%b err=%b rdata=%h mem11=%h want 1 0 11110000 0b0b0b0b", p0_rsp_valid, p0_rsp_err, p0_rsp_rdata, mem[11]);
    end
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    p1_valid = 1; p1_addr = 12'h008;
    @(negedge aclk);
    n_cmp++;
    if (p1_ready !== 1'b1) begin
      n_bad++; $display("FAIL midflight_issue: rdy1=%b want 1", p1_ready);
    end
    next_cycle();
    idle();
    areset = 1;
    @(negedge aclk);
    n_cmp++;
    if (p1_rsp_valid !== 1'b0 || p1_rsp_rdata !== 32'h0) begin
      n_bad++; $display("FAIL midflight_rsp: v1=%b rdata=%h want 0 0", p1_rsp_valid, p1_rsp_rdata);
    end
    next_cycle();
    areset = 0;
    @(negedge aclk);
    n_cmp++;
    if (p1_rsp_valid !== 1'b0 || p0_rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL midflight_after: v1=%b v0=%b want 0 0", p1_rsp_valid, p0_rsp_valid);
    end
    next_cycle();
    p0_valid = 1; p0_addr = 12'h000; p1_valid = 1; p1_addr = 12'h00C;
    @(negedge aclk);
    n_cmp++;
    if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
      n_bad++; $display("FAIL midflight_owner: rdy0=%b rdy1=%b want 1 0", p0_ready, p1_ready);
    end
    next_cycle();
    idle();
    next_cycle();
  endtask

  task automatic test_burst_saturate();
    do_reset();
    p0_valid = 1; p0_addr = 12'h000;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      n_cmp++;
      if (p0_ready !== 1'b1 || p1_ready !== 1'b0) begin
        n_bad++; $display("FAIL solo_burst[%0d]: rdy0=%b rdy1=%b want 1 0", i, p0_ready, p1_ready);
      end
      next_cycle();
    end
    p1_valid = 1; p1_addr = 12'h004;
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      n_cmp++;
      if (p0_ready !== 1'b0 || p1_ready !== 1'b1) begin
        n_bad++; $display("FAIL handover[%0d]: rdy0=%b rdy1=%b want 0 1", i, p0_ready, p1_ready);
      end
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0]  = 32'h11110000;
    mem[1]  = 32'hAABBCCDD;
    mem[2]  = 32'hDEADBEEF;
    mem[3]  = 32'h33333333;
    mem[11] = 32'h0B0B0B0B;
    idle();
    areset = 1;
    test_reset();
    test_read();
    test_contention();
    test_write_read();
    test_errors();
    test_reset_midflight();
    test_burst_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
